// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold-until-release ownership and a single outstanding split.
// A split master is masked until its slave signals done, then re-granted with top priority.
module bus_arbiter #(
    parameter int unsigned MASTER_NO = 2,
    parameter int unsigned SLAVE_NO  = 3,
    parameter int unsigned MID_W     = $clog2(MASTER_NO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MASTER_NO-1:0] m_bus_req,
    output logic [MASTER_NO-1:0] m_bus_grant,
    output logic [MASTER_NO-1:0] m_split_en,
    input  logic [SLAVE_NO-1:0]  s_split,
    input  logic [SLAVE_NO-1:0]  s_split_done,
    output logic [MID_W-1:0]     grant_id,
    output logic                 bus_busy
);

    localparam int unsigned SID_W = (SLAVE_NO > 1) ? $clog2(SLAVE_NO) : 1;
    localparam int unsigned IDX_W = MID_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [MASTER_NO-1:0]   grant_q, grant_d;
    logic [MASTER_NO-1:0]   split_en_q, split_en_d;
    logic [MID_W-1:0]       grant_id_q, grant_id_d;
    logic                   busy_q, busy_d;
    logic [MID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   split_pend_q, split_pend_d;
    logic                   split_resume_q, split_resume_d;
    logic [MID_W-1:0]       split_mid_q, split_mid_d;
    logic [SID_W-1:0]       split_sid_q, split_sid_d;

    logic [MASTER_NO-1:0]   split_mask;
    logic [MASTER_NO-1:0]   eligible;
    logic                   sel_valid;
    logic [MID_W-1:0]       sel_id;
    logic [IDX_W-1:0]       scan_idx;
    logic [MID_W-1:0]       scan_id;
    logic [SID_W-1:0]       split_low_sid;

    function automatic logic [MID_W-1:0] next_id(input logic [MID_W-1:0] id);
        if (32'(id) + 32'd1 >= 32'(MASTER_NO)) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // Winner selection: resuming split master first, else round-robin from rr_ptr
    always_comb begin
        split_mask = '0;
        if (split_pend_q && !split_resume_q) begin
            split_mask[split_mid_q] = 1'b1;
        end
        eligible  = m_bus_req & ~split_mask;
        sel_valid = 1'b0;
        sel_id    = '0;
        scan_idx  = '0;
        scan_id   = '0;
        if (split_resume_q && m_bus_req[split_mid_q]) begin
            sel_valid = 1'b1;
            sel_id    = split_mid_q;
        end else begin
            for (int unsigned k = 0; k < MASTER_NO; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
                if (scan_idx >= IDX_W'(MASTER_NO)) begin
                    scan_idx = scan_idx - IDX_W'(MASTER_NO);
                end
                scan_id = scan_idx[MID_W-1:0];
                if (!sel_valid && eligible[scan_id]) begin
                    sel_valid = 1'b1;
                    sel_id    = scan_id;
                end
            end
        end
    end

    // Lowest-index slave asking for a split
    always_comb begin
        split_low_sid = '0;
        for (int k = int'(SLAVE_NO) - 1; k >= 0; k--) begin
            if (s_split[k]) begin
                split_low_sid = SID_W'(k);
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        split_en_d     = split_en_q;
        grant_id_d     = grant_id_q;
        busy_d         = busy_q;
        rr_ptr_d       = rr_ptr_q;
        split_pend_d   = split_pend_q;
        split_resume_d = split_resume_q;
        split_mid_d    = split_mid_q;
        split_sid_d    = split_sid_q;

        if (split_pend_q && !split_resume_q && s_split_done[split_sid_q]) begin
            split_resume_d = 1'b1;
        end

        case (state_q)
            IDLE, RELEASE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (sel_valid) begin
                    state_d         = GRANT;
                    grant_d         = '0;
                    grant_d[sel_id] = 1'b1;
                    grant_id_d      = sel_id;
                    busy_d          = 1'b1;
                    if (split_resume_q && (sel_id == split_mid_q)) begin
                        split_en_d     = '0;
                        split_pend_d   = 1'b0;
                        split_resume_d = 1'b0;
                    end
                end
            end
            GRANT: begin
                // A split outranks a simultaneous request drop: the master still owes the transfer
                if ((s_split != '0) && !split_pend_q) begin
                    split_mid_d             = grant_id_q;
                    split_sid_d             = split_low_sid;
                    split_pend_d            = 1'b1;
                    split_resume_d          = 1'b0;
                    split_en_d              = '0;
                    split_en_d[grant_id_q]  = 1'b1;
                    grant_d                 = '0;
                    busy_d                  = 1'b0;
                    rr_ptr_d                = next_id(grant_id_q);
                    state_d                 = RELEASE;
                end else if (!m_bus_req[grant_id_q]) begin
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = next_id(grant_id_q);
                    state_d  = RELEASE;
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            split_en_q     <= '0;
            grant_id_q     <= '0;
            busy_q         <= 1'b0;
            rr_ptr_q       <= '0;
            split_pend_q   <= 1'b0;
            split_resume_q <= 1'b0;
            split_mid_q    <= '0;
            split_sid_q    <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            split_en_q     <= split_en_d;
            grant_id_q     <= grant_id_d;
            busy_q         <= busy_d;
            rr_ptr_q       <= rr_ptr_d;
            split_pend_q   <= split_pend_d;
            split_resume_q <= split_resume_d;
            split_mid_q    <= split_mid_d;
            split_sid_q    <= split_sid_d;
        end
    end

    assign m_bus_grant = grant_q;
    assign m_split_en  = split_en_q;
    assign grant_id    = grant_id_q;
    assign bus_busy    = busy_q;

endmodule
